iso14443a_tag_frontend: RTL and testbench

Parametrised ISO14443-A tag-side front end for the HF FPGA image. Combines a windowed pause detector with hysteresis on the ADC stream, a subcarrier load-modulation generator and a free-running SSP serial link to the ARM. It sits between the ADC/antenna driver pins and the SSP port. It extends the fixed-width tag-sim path with a configurable ADC width, SSP framing, subcarrier rate and thresholds, and a direct (no-subcarrier) modulation mode.

---
 rtl/iso14443a_tag_frontend_if.sv | 26 ++
 rtl/iso14443a_tag_frontend.sv | 179 +++++++++++++++++
 tb/tb_iso14443a_tag_frontend.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iso14443a_tag_frontend_if.sv
// Pin bundle between the ISO14443-A tag front end and its surroundings:
// mode select, ADC samples and the SSP link to the ARM.
interface iso14443a_tag_frontend_if #(
  parameter int ADC_WIDTH = 8
);
  logic [2:0]           mod_type;
  logic [ADC_WIDTH-1:0] adc_d;
  logic                 ssp_dout;
  logic                 ssp_clk;
  logic                 ssp_frame;
  logic                 ssp_din;
  logic                 mod_out;
  logic                 pause_det;

  // Driver of mode/ADC/ARM data, observer of the front-end outputs.
  modport master (
    output mod_type, adc_d, ssp_dout,
    input  ssp_clk, ssp_frame, ssp_din, mod_out, pause_det
  );

  // The front end itself.
  modport slave (
    input  mod_type, adc_d, ssp_dout,
    output ssp_clk, ssp_frame, ssp_din, mod_out, pause_det
  );
endinterface

// File: rtl/iso14443a_tag_frontend.sv
// ISO14443-A tag-side front end: windowed pause detector with hysteresis,
// free-running SSP link to the ARM and subcarrier load-modulation generator.
module iso14443a_tag_frontend #(
  parameter int ADC_WIDTH   = 8,
  parameter int LOW_THRESH  = 16,
  parameter int HIGH_THRESH = 64,
  parameter int SSP_DIV     = 16,
  parameter int FRAME_BITS  = 8,
  parameter int SUB_DIV     = 16
) (
  input logic                   ck_1356meg,
  input logic                   rst_n,
  iso14443a_tag_frontend_if.slave bus
);

  localparam int CW = $clog2(SSP_DIV);
  localparam int BW = $clog2(FRAME_BITS);
  localparam int SW = $clog2(SUB_DIV);

  localparam logic [CW-1:0] C_ZERO  = CW'(0);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_LAST  = CW'(SSP_DIV - 1);
  localparam logic [CW-1:0] C_HALF  = CW'(SSP_DIV / 2);
  localparam logic [BW-1:0] BC_ZERO = BW'(0);
  localparam logic [BW-1:0] BC_ONE  = BW'(1);
  localparam logic [BW-1:0] BC_LAST = BW'(FRAME_BITS - 1);
  localparam logic [SW-1:0] SC_ZERO = SW'(0);
  localparam logic [SW-1:0] SC_ONE  = SW'(1);
  localparam logic [SW-1:0] SC_LAST = SW'(SUB_DIV - 1);
  localparam logic [SW-1:0] SC_HALF = SW'(SUB_DIV / 2);

  localparam logic [ADC_WIDTH-1:0] LOW_T  = ADC_WIDTH'(LOW_THRESH);
  localparam logic [ADC_WIDTH-1:0] HIGH_T = ADC_WIDTH'(HIGH_THRESH);

  localparam logic [2:0] MODE_IDLE   = 3'b000;
  localparam logic [2:0] MODE_LISTEN = 3'b001;
  localparam logic [2:0] MODE_MOD    = 3'b010;
  localparam logic [2:0] MODE_MOD2   = 3'b101;

  // Largest of the four history samples (unsigned).
  function automatic logic [ADC_WIDTH-1:0] max4(input logic [3:0][ADC_WIDTH-1:0] v);
    logic [ADC_WIDTH-1:0] m;
    m = v[0];
    for (int i = 1; i < 4; i++) begin
      if (v[i] > m) begin
        m = v[i];
      end else begin
        m = m;
      end
    end
    return m;
  endfunction

  logic [3:0][ADC_WIDTH-1:0] h_q, h_d;
  logic [ADC_WIDTH-1:0]      wmax_q, wmax_d;
  logic                      pause_det_q, pause_det_d;
  logic [CW-1:0]             c_q, c_d;
  logic [BW-1:0]             bc_q, bc_d;
  logic                      ssp_clk_q, ssp_clk_d;
  logic                      ssp_frame_q, ssp_frame_d;
  logic                      ssp_din_q, ssp_din_d;
  logic                      tx_bit_q, tx_bit_d;
  logic [SW-1:0]             sc_q, sc_d;
  logic [2:0]                mod_type_q, mod_type_d;
  logic                      mod_out_q, mod_out_d;
  logic                      mode_chg_s;
  logic                      subcarrier_s;

  // Pause detector pipeline: sample history, window max, hysteresis decision.
  always_comb begin
    h_d    = {h_q[2:0], bus.adc_d};
    wmax_d = max4(h_q);
    if (wmax_q < LOW_T) begin
      pause_det_d = 1'b1;
    end else if (wmax_q >= HIGH_T) begin
      pause_det_d = 1'b0;
    end else begin
      pause_det_d = pause_det_q;
    end
  end

  // SSP bit divider and frame counter; free-running regardless of mode.
  always_comb begin
    bc_d = bc_q;
    if (c_q == C_LAST) begin
      c_d = C_ZERO;
      if (bc_q == BC_LAST) begin
        bc_d = BC_ZERO;
      end else begin
        bc_d = bc_q + BC_ONE;
      end
    end else begin
      c_d = c_q + C_ONE;
    end
    ssp_clk_d   = (c_q >= C_HALF);
    ssp_frame_d = (bc_q == BC_ZERO);
  end

  // Receive path: pause bit handed to the ARM at the start of each bit period.
  always_comb begin
    case (bus.mod_type)
      MODE_LISTEN: begin
        if (c_q == C_ZERO) begin
          ssp_din_d = pause_det_q;
        end else begin
          ssp_din_d = ssp_din_q;
        end
      end
      default: ssp_din_d = 1'b0;
    endcase
  end

  // Transmit path: latch ARM bit on ssp_clk rise, run subcarrier, drive modulation.
  always_comb begin
    mod_type_d = bus.mod_type;
    mode_chg_s = (bus.mod_type != mod_type_q);
    if (c_q == C_HALF) begin
      tx_bit_d = bus.ssp_dout;
    end else begin
      tx_bit_d = tx_bit_q;
    end
    if (mode_chg_s) begin
      sc_d = SC_ZERO;
    end else if (sc_q == SC_LAST) begin
      sc_d = SC_ZERO;
    end else begin
      sc_d = sc_q + SC_ONE;
    end
    subcarrier_s = (sc_q < SC_HALF);
    if (mode_chg_s) begin
      mod_out_d = 1'b0;
    end else begin
      case (bus.mod_type)
        MODE_MOD:  mod_out_d = tx_bit_q & subcarrier_s;
        MODE_MOD2: mod_out_d = tx_bit_q;
        MODE_IDLE: mod_out_d = 1'b0;
        default:   mod_out_d = 1'b0;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      h_q         <= {4{{ADC_WIDTH{1'b0}}}};
      wmax_q      <= {ADC_WIDTH{1'b0}};
      pause_det_q <= 1'b0;
      c_q         <= C_ZERO;
      bc_q        <= BC_ZERO;
      ssp_clk_q   <= 1'b0;
      ssp_frame_q <= 1'b0;
      ssp_din_q   <= 1'b0;
      tx_bit_q    <= 1'b0;
      sc_q        <= SC_ZERO;
      mod_type_q  <= 3'b000;
      mod_out_q   <= 1'b0;
    end else begin
      h_q         <= h_d;
      wmax_q      <= wmax_d;
      pause_det_q <= pause_det_d;
      c_q         <= c_d;
      bc_q        <= bc_d;
      ssp_clk_q   <= ssp_clk_d;
      ssp_frame_q <= ssp_frame_d;
      ssp_din_q   <= ssp_din_d;
      tx_bit_q    <= tx_bit_d;
      sc_q        <= sc_d;
      mod_type_q  <= mod_type_d;
      mod_out_q   <= mod_out_d;
    end
  end

  assign bus.ssp_clk   = ssp_clk_q;
  assign bus.ssp_frame = ssp_frame_q;
  assign bus.ssp_din   = ssp_din_q;
  assign bus.mod_out   = mod_out_q;
  assign bus.pause_det = pause_det_q;

endmodule

// File: tb/tb_iso14443a_tag_frontend.sv
// Scoreboard bench for iso14443a_tag_frontend with default parameters.
// Stimulus pushes (cycle, signal, value) expectations; the monitor compares
// them on the falling clock edge of the cycle they name.
module tb_iso14443a_tag_frontend;

  localparam int P_SSP_DIV = 16;
  localparam int P_FRAME   = 8;
  localparam int P_SUB_DIV = 16;

  localparam int SIG_CLK   = 0;
  localparam int SIG_FRAME = 1;
  localparam int SIG_DIN   = 2;
  localparam int SIG_MOD   = 3;
  localparam int SIG_PAUSE = 4;

  typedef struct {
    int   cyc;
    int   sig;
    logic val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   r_base = 0;
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;
  exp_t sb_q[$];

  iso14443a_tag_frontend_if #(.ADC_WIDTH(8)) bus_if ();

  iso14443a_tag_frontend #(
    .ADC_WIDTH(8), .LOW_THRESH(16), .HIGH_THRESH(64),
    .SSP_DIV(P_SSP_DIV), .FRAME_BITS(P_FRAME), .SUB_DIV(P_SUB_DIV)
  ) dut (
    .ck_1356meg(clk),
    .rst_n(rst_n),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic sig_val(int id);
    case (id)
      SIG_CLK:   return bus_if.ssp_clk;
      SIG_FRAME: return bus_if.ssp_frame;
      SIG_DIN:   return bus_if.ssp_din;
      SIG_MOD:   return bus_if.mod_out;
      default:   return bus_if.pause_det;
    endcase
  endfunction

  function automatic string sig_name(int id);
    case (id)
      SIG_CLK:   return "ssp_clk";
      SIG_FRAME: return "ssp_frame";
      SIG_DIN:   return "ssp_din";
      SIG_MOD:   return "mod_out";
      default:   return "pause_det";
    endcase
  endfunction

  // First edge after 'after' at which the divider value before the edge is cv.
  function automatic int next_edge(int after, int cv);
    int t;
    t = after + 1;
    while (((t - 1 - r_base) % P_SSP_DIV) != cv) t++;
    return t;
  endfunction

  task automatic expect_at(int at, int id, logic v);
    exp_t e;
    e.cyc = at;
    e.sig = id;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation due this cycle, flag stale/unchecked ones.
  always @(negedge clk) begin
    exp_t keep[$];
    logic got;
    keep = {};
    foreach (sb_q[i]) begin
      if (done || sb_q[i].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s unchecked @cycle %0d: expected %b, never sampled",
                 sig_name(sb_q[i].sig), sb_q[i].cyc, sb_q[i].val);
      end else if (sb_q[i].cyc == cyc) begin
        got = sig_val(sb_q[i].sig);
        checks++;
        if (got !== sb_q[i].val) begin
          failures++;
          $display("FAIL %s @cycle %0d: got %b expected %b",
                   sig_name(sb_q[i].sig), cyc, got, sb_q[i].val);
        end
      end else begin
        keep.push_back(sb_q[i]);
      end
    end
    sb_q = keep;
  end

  initial begin
    int a, b, d, f, x, g, y, hc, j, t;

    // Power-on reset
    rst_n = 1'b0;
    bus_if.mod_type = 3'b000;
    bus_if.adc_d    = 8'd200;
    bus_if.ssp_dout = 1'b0;
    step(3);
    for (int id = 0; id < 5; id++) expect_at(cyc, id, 1'b0);
    step(1);
    rst_n  = 1'b1;
    r_base = cyc;

    // Framing: 512 cycles, clock period 16 at 50%, frame 16 of every 128
    for (int n = 1; n <= 512; n++) begin
      expect_at(r_base + n, SIG_CLK,   ((n - 1) % P_SSP_DIV) >= (P_SSP_DIV / 2));
      expect_at(r_base + n, SIG_FRAME, ((n - 1) % (P_SSP_DIV * P_FRAME)) < P_SSP_DIV);
    end
    expect_at(r_base + 512, SIG_PAUSE, 1'b0);
    expect_at(r_base + 512, SIG_MOD,   1'b0);
    expect_at(r_base + 512, SIG_DIN,   1'b0);
    step(512);

    // Listen latency: assert after 6 edges, release after 3, ssp_din follows at c==0
    a = cyc;
    bus_if.mod_type = 3'b001;
    bus_if.adc_d    = 8'd0;
    expect_at(a + 5, SIG_PAUSE, 1'b0);
    expect_at(a + 6, SIG_PAUSE, 1'b1);
    x = next_edge(a + 6, 0);
    expect_at(x - 1, SIG_DIN, 1'b0);
    expect_at(x,     SIG_DIN, 1'b1);
    step(20);
    bus_if.adc_d = 8'd200;
    expect_at(a + 22, SIG_PAUSE, 1'b1);
    expect_at(a + 23, SIG_PAUSE, 1'b0);
    x = next_edge(a + 23, 0);
    expect_at(x - 1, SIG_DIN, 1'b1);
    expect_at(x,     SIG_DIN, 1'b0);
    step(20);

    // Hysteresis, threshold boundaries and glitch immunity
    b = cyc;
    bus_if.adc_d = 8'd0;
    expect_at(b + 6, SIG_PAUSE, 1'b1);
    step(10);
    bus_if.adc_d = 8'd40;
    for (int k = 11; k <= 110; k++) expect_at(b + k, SIG_PAUSE, 1'b1);
    step(100);
    bus_if.adc_d = 8'd63;
    for (int k = 111; k <= 120; k++) expect_at(b + k, SIG_PAUSE, 1'b1);
    step(10);
    bus_if.adc_d = 8'd64;
    expect_at(b + 122, SIG_PAUSE, 1'b1);
    expect_at(b + 123, SIG_PAUSE, 1'b0);
    step(10);
    for (int k = 131; k <= 185; k++) expect_at(b + k, SIG_PAUSE, 1'b0);
    for (int i = 0; i < 40; i++) begin
      bus_if.adc_d = (i % 2 == 0) ? 8'd0 : 8'd200;
      step(1);
    end
    bus_if.adc_d = 8'd16;
    step(15);
    bus_if.adc_d = 8'd15;
    expect_at(b + 190, SIG_PAUSE, 1'b0);
    expect_at(b + 191, SIG_PAUSE, 1'b1);
    step(10);
    bus_if.adc_d = 8'd200;
    expect_at(b + 198, SIG_PAUSE, 1'b0);
    step(5);

    // Modulation: IDLE -> TAGSIM_MOD with tx_bit already 1
    bus_if.mod_type = 3'b000;
    bus_if.ssp_dout = 1'b1;
    step(20);
    d = cyc;
    bus_if.mod_type = 3'b010;
    expect_at(d,     SIG_MOD, 1'b0);
    expect_at(d + 1, SIG_MOD, 1'b0);
    for (int k = 2; k <= 49; k++)
      expect_at(d + k, SIG_MOD, ((k - 2) % P_SUB_DIV) < (P_SUB_DIV / 2));
    step(50);
    f = cyc;
    bus_if.ssp_dout = 1'b0;
    x = next_edge(f, P_SSP_DIV / 2);
    for (int k = 0; k <= 24; k++) begin
      t = f + k;
      expect_at(t, SIG_MOD, (t <= x) ? (((t - d - 2) % P_SUB_DIV) < (P_SUB_DIV / 2)) : 1'b0);
    end
    step(25);

    // TAGSIM_MOD2: mod_out follows tx_bit directly
    g = cyc;
    bus_if.mod_type = 3'b101;
    bus_if.ssp_dout = 1'b1;
    y = next_edge(g, P_SSP_DIV / 2);
    expect_at(g + 1, SIG_MOD, 1'b0);
    for (int k = 2; k <= 30; k++) expect_at(g + k, SIG_MOD, (g + k) > y);
    step(30);

    // Invalid codes after a listen phase that left ssp_din high
    bus_if.mod_type = 3'b001;
    bus_if.adc_d    = 8'd0;
    step(40);
    hc = cyc;
    expect_at(hc, SIG_DIN,   1'b1);
    expect_at(hc, SIG_PAUSE, 1'b1);
    for (int m = 0; m < 2; m++) begin
      bus_if.mod_type = (m == 0) ? 3'b011 : 3'b111;
      for (int k = 1; k <= 30; k++) begin
        t = hc + 30 * m + k;
        expect_at(t, SIG_DIN,   1'b0);
        expect_at(t, SIG_MOD,   1'b0);
        expect_at(t, SIG_PAUSE, 1'b1);
        expect_at(t, SIG_CLK,   ((t - 1 - r_base) % P_SSP_DIV) >= (P_SSP_DIV / 2));
      end
      step(30);
    end

    // Reset mid-operation with mod_out high, then restart timing
    j = cyc;
    bus_if.mod_type = 3'b010;
    step(4);
    expect_at(j + 4, SIG_MOD, 1'b1);
    step(1);
    rst_n = 1'b0;
    for (int id = 0; id < 5; id++) expect_at(j + 5, id, 1'b0);
    step(3);
    for (int id = 0; id < 5; id++) expect_at(j + 8, id, 1'b0);
    rst_n  = 1'b1;
    r_base = cyc;
    expect_at(r_base + 8,  SIG_CLK,   1'b0);
    expect_at(r_base + 9,  SIG_CLK,   1'b1);
    expect_at(r_base + 1,  SIG_FRAME, 1'b1);
    expect_at(r_base + 16, SIG_FRAME, 1'b1);
    expect_at(r_base + 17, SIG_FRAME, 1'b0);
    for (int k = 1; k <= 9; k++) expect_at(r_base + k, SIG_MOD, 1'b0);
    expect_at(r_base + 17, SIG_MOD, 1'b0);
    expect_at(r_base + 18, SIG_MOD, 1'b1);
    step(20);

    step(2);
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
